// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC scan controller.
// No logic; constants only.
// No flow control.
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ADVANCE,
    S_FINISH
  } state_e;

  // The sequencer never terminates for a coarse stop of 254 or 255.
  localparam logic [7:0] T_COARSE_MAX    = 8'd253;
  // Cycles of ready=1 after a run request before the sequencer is declared stuck.
  localparam int         SEQ_ACK_TIMEOUT = 4;

  // status bit positions: {cfg_error, overflow, protocol_error, aborted}
  localparam int ST_ABORTED   = 0;
  localparam int ST_PROTOCOL  = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_CFG_ERROR = 3;

  typedef struct packed {
    logic [7:0]  t_start;
    logic [7:0]  stop_first;
    logic [7:0]  stop_last;
    logic [7:0]  stop_step;
    logic [15:0] reps;
  } scan_cfg_t;

endpackage

// File: rtl/tdc_ram_addr_counter.sv
// RAM write address register with space-remaining check for one full run.
// Address advances on the edge ending each write cycle; space_ok is combinational.
// No backpressure; inc is a write strobe that is always accepted.
module tdc_ram_addr_counter #(
  parameter int ADDR_WIDTH    = 12,
  parameter int WORDS_PER_RUN = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  space_ok
);
  // One extra bit so a completely filled RAM reads as "depth" rather than
  // wrapping to 0; the port only shows the low ADDR_WIDTH bits.
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] RUN_WORDS = WORDS_PER_RUN[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] addr_q, addr_d;

  // Next address: clear at scan start, step once per written word.
  always_comb begin
    addr_d = addr_q;
    if (clr)      addr_d = '0;
    else if (inc) addr_d = addr_q + 1'b1;
  end

  // Address register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr_d;
  end

  assign addr     = addr_q[ADDR_WIDTH-1:0];
  assign space_ok = (DEPTH - addr_q) >= RUN_WORDS;

endmodule

// File: rtl/tdc_scan_controller.sv
// Sweeps the TDC sequencer over a range of coarse stops, N runs per point.
// One-cycle run request one cycle after LAUNCH sees ready; 2-cycle inter-run overhead.
// Waits on sequencer ready; no backpressure on RAM writes (ram_we = seq_write & busy).
module tdc_scan_controller
  import tdc_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int WORDS_PER_RUN = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scan_start,
  input  logic                  scan_abort,
  input  logic [7:0]            cfg_t_start,
  input  logic [7:0]            cfg_t_stop_first,
  input  logic [7:0]            cfg_t_stop_last,
  input  logic [7:0]            cfg_t_stop_step,
  input  logic [15:0]           cfg_repetitions,
  input  logic                  seq_ready,
  input  logic                  seq_write,
  output logic                  seq_run,
  output logic [7:0]            t_start_coarse,
  output logic [7:0]            t_stop_coarse,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            status,
  output logic [23:0]           runs_completed
);

  state_e      state_q, state_d;
  scan_cfg_t   cfg_q, cfg_d;
  logic [7:0]  stop_q, stop_d;
  logic [15:0] rep_q, rep_d;
  logic [15:0] wc_q, wc_d;
  logic [2:0]  wb_q, wb_d;
  logic        seq_run_q, seq_run_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  status_q, status_d;
  logic [23:0] runs_q, runs_d;

  logic        addr_clr;
  logic        space_ok;
  logic        finish_req;
  logic        abort_now;
  logic [8:0]  next_stop;
  logic [15:0] reps_eff;
  logic [15:0] wc_total;

  // Writes only reach the RAM while a scan owns the sequencer.
  assign ram_we = seq_write & busy_q;

  tdc_ram_addr_counter #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .WORDS_PER_RUN (WORDS_PER_RUN)
  ) u_addr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (addr_clr),
    .inc      (ram_we),
    .addr     (ram_addr),
    .space_ok (space_ok)
  );

  assign abort_now = status_q[ST_ABORTED] | scan_abort;
  assign next_stop = {1'b0, stop_q} + {1'b0, cfg_q.stop_step};
  assign reps_eff  = (cfg_q.reps == 16'd0) ? 16'd1 : cfg_q.reps;
  assign wc_total  = wc_q + {15'd0, seq_write};

  // Scan sequencing: next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    stop_d     = stop_q;
    rep_d      = rep_q;
    wc_d       = wc_q;
    wb_d       = wb_q;
    seq_run_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    status_d   = status_q;
    runs_d     = runs_q;
    addr_clr   = 1'b0;
    finish_req = 1'b0;

    // Abort is a sticky request; in-flight runs still complete.
    if (state_q != S_IDLE && state_q != S_FINISH && scan_abort)
      status_d[ST_ABORTED] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          cfg_d = '{t_start:    cfg_t_start,
                    stop_first: cfg_t_stop_first,
                    stop_last:  cfg_t_stop_last,
                    stop_step:  cfg_t_stop_step,
                    reps:       cfg_repetitions};
          status_d = '0;
          runs_d   = '0;
          addr_clr = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_q.stop_first < cfg_q.t_start ||
            cfg_q.stop_last < cfg_q.stop_first ||
            cfg_q.stop_last > T_COARSE_MAX) begin
          status_d[ST_CFG_ERROR] = 1'b1;
          finish_req = 1'b1;
        end else begin
          stop_d  = cfg_q.stop_first;
          rep_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!space_ok) begin
          status_d[ST_OVERFLOW] = 1'b1;
          finish_req = 1'b1;
        end else if (abort_now) begin
          finish_req = 1'b1;
        end else if (seq_ready) begin
          // Registered request: high next cycle, while ready is still 1.
          seq_run_d = 1'b1;
          wc_d      = '0;
          wb_d      = '0;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!seq_ready) begin
          wc_d    = {15'd0, seq_write};
          state_d = S_WAIT_DONE;
        end else if (wb_q == 3'(SEQ_ACK_TIMEOUT - 1)) begin
          status_d[ST_PROTOCOL] = 1'b1;
          finish_req = 1'b1;
        end else begin
          wb_d = wb_q + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        if (seq_write) wc_d = wc_q + 16'd1;
        if (seq_ready) begin
          runs_d = runs_q + 24'd1;
          if (wc_total != 16'(WORDS_PER_RUN)) status_d[ST_PROTOCOL] = 1'b1;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (abort_now) begin
          finish_req = 1'b1;
        end else if (({1'b0, rep_q} + 17'd1) < {1'b0, reps_eff}) begin
          rep_d   = rep_q + 16'd1;
          state_d = S_LAUNCH;
        end else if (cfg_q.stop_step == 8'd0 || next_stop > {1'b0, cfg_q.stop_last}) begin
          finish_req = 1'b1;
        end else begin
          stop_d  = next_stop[7:0];
          rep_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // busy falls in the same cycle done pulses.
    if (finish_req) begin
      state_d = S_FINISH;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      stop_q    <= '0;
      rep_q     <= '0;
      wc_q      <= '0;
      wb_q      <= '0;
      seq_run_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
      runs_q    <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      stop_q    <= stop_d;
      rep_q     <= rep_d;
      wc_q      <= wc_d;
      wb_q      <= wb_d;
      seq_run_q <= seq_run_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      runs_q    <= runs_d;
    end
  end

  assign seq_run        = seq_run_q;
  assign t_start_coarse = cfg_q.t_start;
  assign t_stop_coarse  = stop_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign status         = status_q;
  assign runs_completed = runs_q;

endmodule

// File: tb/tb_tdc_scan_controller.sv
// Bench for tdc_scan_controller: behavioural sequencer plus scan-level reference model.
// Each scan is predicted from its config and per-run sequencer behaviour, then compared.
// The sequencer model holds ready until it has sampled a run request.
module tb_tdc_scan_controller;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int WPR   = 8;

  logic          clk;
  logic          reset_n;
  logic          scan_start;
  logic          scan_abort;
  logic [7:0]    cfg_t_start;
  logic [7:0]    cfg_t_stop_first;
  logic [7:0]    cfg_t_stop_last;
  logic [7:0]    cfg_t_stop_step;
  logic [15:0]   cfg_repetitions;
  logic          seq_ready;
  logic          seq_write;
  logic          seq_run;
  logic [7:0]    t_start_coarse;
  logic [7:0]    t_stop_coarse;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          busy;
  logic          done;
  logic [3:0]    status;
  logic [23:0]   runs_completed;

  tdc_scan_controller #(.ADDR_WIDTH(AW), .WORDS_PER_RUN(WPR)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .scan_start       (scan_start),
    .scan_abort       (scan_abort),
    .cfg_t_start      (cfg_t_start),
    .cfg_t_stop_first (cfg_t_stop_first),
    .cfg_t_stop_last  (cfg_t_stop_last),
    .cfg_t_stop_step  (cfg_t_stop_step),
    .cfg_repetitions  (cfg_repetitions),
    .seq_ready        (seq_ready),
    .seq_write        (seq_write),
    .seq_run          (seq_run),
    .t_start_coarse   (t_start_coarse),
    .t_stop_coarse    (t_stop_coarse),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .busy             (busy),
    .done             (done),
    .status           (status),
    .runs_completed   (runs_completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Per-run sequencer behaviour: extra cycles ready stays high, words written.
  int m_hold   [0:1023];
  int m_writes [0:1023];
  int seq_idx;
  bit seq_active;

  int obs_stops[$];
  int exp_stops[$];
  int done_cnt;
  int we_cnt;
  int cur_start;
  int e_runs, e_addr, e_status;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic seq_defaults();
    for (int i = 0; i < 1024; i++) begin
      m_hold[i]   = 0;
      m_writes[i] = WPR;
    end
  endtask

  // Scan-level prediction: walk points and repetitions, apply overflow and
  // sequencer misbehaviour rules per run.
  function automatic void model_scan(int st, int f, int l, int sp, int reps);
    int reps_eff;
    int stop;
    int k;
    bit fin;
    reps_eff = (reps == 0) ? 1 : reps;
    k = 0;
    fin = 0;
    exp_stops.delete();
    e_runs = 0;
    e_addr = 0;
    e_status = 0;
    if (f < st || l < f || l > 253) begin
      e_status = 8;
      return;
    end
    stop = f;
    while (!fin) begin
      for (int r = 0; r < reps_eff && !fin; r++) begin
        if (DEPTH - e_addr < WPR) begin
          e_status |= 4;
          fin = 1;
        end else begin
          exp_stops.push_back(stop);
          if (m_hold[k] + 1 >= 4) begin
            e_status |= 2;
            fin = 1;
          end else begin
            e_addr += m_writes[k];
            e_runs++;
            if (m_writes[k] != WPR) e_status |= 2;
          end
          k++;
        end
      end
      if (!fin) begin
        if (sp == 0 || stop + sp > l) fin = 1;
        else stop += sp;
      end
    end
  endfunction

  // Behavioural sequencer: ready drops one cycle after the request is
  // sampled (later if told to hold), then streams its words.
  initial begin
    int h;
    int w;
    seq_ready  = 1'b1;
    seq_write  = 1'b0;
    seq_active = 1'b0;
    seq_idx    = 0;
    forever begin
      @(negedge clk);
      if (seq_run === 1'b1 && seq_ready === 1'b1) begin
        seq_active = 1'b1;
        h = (seq_idx < 1024) ? m_hold[seq_idx] : 0;
        w = (seq_idx < 1024) ? m_writes[seq_idx] : WPR;
        seq_idx++;
        @(posedge clk);
        repeat (h) @(posedge clk);
        #1 seq_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < w; i++) begin
          seq_write = 1'b1;
          @(posedge clk);
          #1;
        end
        seq_write  = 1'b0;
        seq_ready  = 1'b1;
        seq_active = 1'b0;
      end
    end
  end

  // Observer: record each run request and check write addresses are sequential.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (seq_run === 1'b1) begin
        obs_stops.push_back(int'(t_stop_coarse));
        check("run_start_coarse", t_start_coarse, cur_start);
        check("run_needs_ready", seq_ready, 1);
      end
      if (done === 1'b1) done_cnt++;
      if (ram_we === 1'b1) begin
        check("ram_addr_seq", ram_addr, we_cnt % DEPTH);
        we_cnt++;
      end
    end
  end

  task automatic wait_seq_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((seq_active || seq_ready !== 1'b1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_seq_idle"}, seq_active, 0);
  endtask

  task automatic start_scan(input int st, input int f, input int l, input int sp, input int reps);
    obs_stops.delete();
    done_cnt  = 0;
    we_cnt    = 0;
    seq_idx   = 0;
    cur_start = st;
    @(negedge clk);
    cfg_t_start      = st[7:0];
    cfg_t_stop_first = f[7:0];
    cfg_t_stop_last  = l[7:0];
    cfg_t_stop_step  = sp[7:0];
    cfg_repetitions  = reps[15:0];
    scan_start       = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  // Wait for done (bounded) and compare the scan's results with the prediction.
  task automatic finish_scan(input string tag, output int lat);
    int cyc;
    check({tag, "_busy_rise"}, busy, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_status"}, status, e_status);
    check({tag, "_runs"}, runs_completed, e_runs);
    check({tag, "_ram_addr"}, ram_addr, e_addr % DEPTH);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_runs_issued"}, obs_stops.size(), exp_stops.size());
    for (int i = 0; i < exp_stops.size() && i < obs_stops.size(); i++)
      check($sformatf("%s_stop%0d", tag, i), obs_stops[i], exp_stops[i]);
    wait_seq_idle(tag);
  endtask

  task automatic run_scan(input string tag, input int st, input int f, input int l,
                          input int sp, input int reps, output int lat);
    model_scan(st, f, l, sp, reps);
    start_scan(st, f, l, sp, reps);
    finish_scan(tag, lat);
  endtask

  initial begin
    int lat;
    int cyc;
    int st, f, l, sp, reps;

    reset_n          = 1'b0;
    scan_start       = 1'b0;
    scan_abort       = 1'b0;
    cfg_t_start      = '0;
    cfg_t_stop_first = '0;
    cfg_t_stop_last  = '0;
    cfg_t_stop_step  = '0;
    cfg_repetitions  = '0;
    done_cnt         = 0;
    we_cnt           = 0;
    cur_start        = 0;
    seq_defaults();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seq_run", seq_run, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_runs", runs_completed, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_t_stop", t_stop_coarse, 0);
    check("rst_t_start", t_start_coarse, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single point, three repetitions
    seq_defaults();
    run_scan("single", 10, 20, 20, 0, 3, lat);

    // Sweep with step that overshoots the last stop
    seq_defaults();
    run_scan("sweep", 5, 20, 40, 7, 1, lat);

    // Config errors finish two cycles after the start pulse
    seq_defaults();
    run_scan("cfg_last254", 10, 20, 254, 1, 1, lat);
    check("cfg_last254_latency", lat, 2);
    run_scan("cfg_first_lt_start", 10, 5, 20, 1, 1, lat);
    check("cfg_first_lt_start_latency", lat, 2);

    // RAM fills exactly; the next run is never launched
    seq_defaults();
    run_scan("overflow", 0, 50, 50, 0, 600, lat);

    // Sequencer never acknowledges in time
    seq_defaults();
    m_hold[0] = 5;
    run_scan("ack_timeout", 3, 30, 30, 0, 2, lat);

    // Wrong word count on one run: flagged, scan continues
    seq_defaults();
    m_writes[1] = 7;
    run_scan("bad_words", 3, 30, 30, 0, 3, lat);

    // Abort during the second of five runs
    seq_defaults();
    model_scan(0, 30, 30, 0, 5);
    start_scan(0, 30, 30, 0, 5);
    cyc = 0;
    while (!(obs_stops.size() == 2 && seq_ready === 1'b0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_run2", obs_stops.size(), 2);
    scan_abort = 1'b1;
    exp_stops.delete();
    exp_stops.push_back(30);
    exp_stops.push_back(30);
    e_runs   = 2;
    e_addr   = 16;
    e_status = 1;
    finish_scan("abort", lat);
    scan_abort = 1'b0;

    // Reset asserted mid-run clears every output at once
    seq_defaults();
    start_scan(0, 10, 10, 0, 4);
    cyc = 0;
    while (!(obs_stops.size() == 1 && seq_write === 1'b1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun_writing", seq_write, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ram_we", ram_we, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_runs", runs_completed, 0);
    check("midrst_status", status, 0);
    check("midrst_t_stop", t_stop_coarse, 0);
    check("midrst_t_start", t_start_coarse, 0);
    check("midrst_seq_run", seq_run, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_seq_idle("midrst");

    // Randomised scans
    for (int n = 0; n < 6; n++) begin
      st   = $urandom_range(40);
      f    = $urandom_range(80);
      l    = f - 3 + $urandom_range(63);
      if (l < 0) l = 0;
      if (l > 255) l = 255;
      sp   = $urandom_range(20);
      reps = $urandom_range(3);
      for (int i = 0; i < 1024; i++) begin
        m_hold[i]   = $urandom_range(2);
        m_writes[i] = ($urandom_range(15) == 0) ? WPR - 1 : WPR;
      end
      run_scan($sformatf("rnd%0d", n), st, f, l, sp, reps, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
